// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round sequencer: READY -> PLAY -> SHOW -> score loop feeding the matrix display.
// Optional play-phase timeout is enabled by defining RPS_TIMEOUT_EN.
module rps_round_ctrl #(
    parameter int unsigned READY_CYCLES   = 50_000_000,
    parameter int unsigned SHOW_CYCLES    = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned WIN_SCORE      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_key,
    input  logic [2:0] btn_left,
    input  logic [2:0] btn_right,
    output logic       ready_pulse,
    output logic       start_pulse,
    output logic [2:0] new_button_left,
    output logic [2:0] new_button_right,
    output logic [2:0] grade_left,
    output logic [2:0] grade_right,
    output logic       match_over,
    output logic       winner_left
);

    typedef enum logic [2:0] {
        StIdle,
        StReady,
        StPlay,
        StShow,
        StOver
    } state_e;

    localparam logic [2:0] Rock     = 3'b001;
    localparam logic [2:0] Scissors = 3'b010;
    localparam logic [2:0] Paper    = 3'b100;

    localparam logic [31:0] ReadyLast = 32'(READY_CYCLES - 1);
    localparam logic [31:0] ShowLast  = 32'(SHOW_CYCLES - 1);
    localparam logic [2:0]  WinGrade  = 3'(WIN_SCORE);

`ifdef RPS_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == Rock) || (v == Scissors) || (v == Paper);
    endfunction

    // A missing (000) opponent throw only occurs after a play timeout; the latched side wins.
    function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
        return ((a == Rock) && (b == Scissors)) ||
               ((a == Scissors) && (b == Paper)) ||
               ((a == Paper) && (b == Rock)) ||
               ((a != 3'b000) && (b == 3'b000));
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  throw_l_q, throw_l_d;
    logic [2:0]  throw_r_q, throw_r_d;
    logic [2:0]  grade_l_q, grade_l_d;
    logic [2:0]  grade_r_q, grade_r_d;
    logic        winner_q, winner_d;
    logic        ready_pulse_q, ready_pulse_d;
    logic        start_pulse_q, start_pulse_d;
    logic        match_over_q, match_over_d;

    logic left_win, right_win;
    assign left_win  = beats(throw_l_q, throw_r_q);
    assign right_win = beats(throw_r_q, throw_l_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        throw_l_d = throw_l_q;
        throw_r_d = throw_r_q;
        grade_l_d = grade_l_q;
        grade_r_d = grade_r_q;
        winner_d  = winner_q;

        unique case (state_q)
            StIdle: begin
                if (start_key) begin
                    state_d   = StReady;
                    cnt_d     = '0;
                    grade_l_d = '0;
                    grade_r_d = '0;
                    throw_l_d = '0;
                    throw_r_d = '0;
                end
            end

            StReady: begin
                if (cnt_q == ReadyLast) begin
                    state_d = StPlay;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StPlay: begin
                if ((throw_l_q == 3'b000) && is_onehot3(btn_left)) begin
                    throw_l_d = btn_left;
                end
                if ((throw_r_q == 3'b000) && is_onehot3(btn_right)) begin
                    throw_r_d = btn_right;
                end
                if ((throw_l_d != 3'b000) && (throw_r_d != 3'b000)) begin
                    state_d = StShow;
                    cnt_d   = '0;
`ifdef RPS_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d = '0;
                    if ((throw_l_d != 3'b000) || (throw_r_d != 3'b000)) begin
                        state_d = StShow;
                    end else begin
                        state_d = StReady;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end

            StShow: begin
                if (cnt_q == ShowLast) begin
                    cnt_d   = '0;
                    state_d = StReady;
                    if (left_win && (grade_l_q < WinGrade)) begin
                        grade_l_d = grade_l_q + 3'd1;
                    end
                    if (right_win && (grade_r_q < WinGrade)) begin
                        grade_r_d = grade_r_q + 3'd1;
                    end
                    if (left_win && (grade_l_d == WinGrade)) begin
                        state_d  = StOver;
                        winner_d = 1'b1;
                    end else if (right_win && (grade_r_d == WinGrade)) begin
                        state_d  = StOver;
                        winner_d = 1'b0;
                    end else begin
                        throw_l_d = '0;
                        throw_r_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            StOver: begin
                if (start_key) begin
                    state_d   = StReady;
                    cnt_d     = '0;
                    grade_l_d = '0;
                    grade_r_d = '0;
                    throw_l_d = '0;
                    throw_r_d = '0;
                    winner_d  = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        ready_pulse_d = (state_d == StReady) || (state_d == StPlay);
        start_pulse_d = (state_d == StPlay) || (state_d == StShow);
        match_over_d  = (state_d == StOver);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            throw_l_q     <= '0;
            throw_r_q     <= '0;
            grade_l_q     <= '0;
            grade_r_q     <= '0;
            winner_q      <= 1'b0;
            ready_pulse_q <= 1'b0;
            start_pulse_q <= 1'b0;
            match_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            throw_l_q     <= throw_l_d;
            throw_r_q     <= throw_r_d;
            grade_l_q     <= grade_l_d;
            grade_r_q     <= grade_r_d;
            winner_q      <= winner_d;
            ready_pulse_q <= ready_pulse_d;
            start_pulse_q <= start_pulse_d;
            match_over_q  <= match_over_d;
        end
    end

    assign ready_pulse      = ready_pulse_q;
    assign start_pulse      = start_pulse_q;
    assign new_button_left  = throw_l_q;
    assign new_button_right = throw_r_q;
    assign grade_left       = grade_l_q;
    assign grade_right      = grade_r_q;
    assign match_over       = match_over_q;
    assign winner_left      = winner_q;

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Scoreboard bench for rps_round_ctrl: expected output vectors are queued per cycle and
// compared at the falling edge. Timeout scenarios run when RPS_TIMEOUT_EN is defined.
module tb_rps_round_ctrl;

    localparam int unsigned ReadyCycles   = 4;
    localparam int unsigned ShowCycles    = 3;
    localparam int unsigned TimeoutCycles = 10;
    localparam int unsigned WinScore      = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_key;
    logic [2:0] btn_left;
    logic [2:0] btn_right;
    logic       ready_pulse;
    logic       start_pulse;
    logic [2:0] new_button_left;
    logic [2:0] new_button_right;
    logic [2:0] grade_left;
    logic [2:0] grade_right;
    logic       match_over;
    logic       winner_left;

    rps_round_ctrl #(
        .READY_CYCLES  (ReadyCycles),
        .SHOW_CYCLES   (ShowCycles),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .WIN_SCORE     (WinScore)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_key       (start_key),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .ready_pulse     (ready_pulse),
        .start_pulse     (start_pulse),
        .new_button_left (new_button_left),
        .new_button_right(new_button_right),
        .grade_left      (grade_left),
        .grade_right     (grade_right),
        .match_over      (match_over),
        .winner_left     (winner_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          gl_m = 0;
    int          gr_m = 0;
    logic [15:0] obs;
    logic [15:0] over_vec;

    assign obs = {ready_pulse, start_pulse, new_button_left, new_button_right,
                  grade_left, grade_right, match_over, winner_left};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b (rp,sp,nbl,nbr,gl,gr,mo,wl)", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_mon = sb.pop_front();
            check_eq(e_mon.tag, obs, e_mon.v);
        end
    end

    function automatic logic [15:0] mk(input logic rp, input logic sp, input logic [2:0] nl,
                                       input logic [2:0] nr, input int gl, input int gr,
                                       input logic mo, input logic wl);
        return {rp, sp, nl, nr, 3'(gl), 3'(gr), mo, wl};
    endfunction

    function automatic int idx(input logic [2:0] b);
        case (b)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    // rock=0, scissors=1, paper=2: a beats b when b == a+1 (mod 3); a lone throw wins.
    function automatic logic wins(input logic [2:0] a, input logic [2:0] b);
        int ia, ib;
        ia = idx(a);
        ib = idx(b);
        if (ia < 0) return 1'b0;
        if (ib < 0) return 1'b1;
        return ((ia + 1) % 3) == ib;
    endfunction

    task automatic step(input string tag, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc + 1;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ready_v();
        return mk(1'b1, 1'b0, 3'b000, 3'b000, gl_m, gr_m, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] play_v(input logic [2:0] nl, input logic [2:0] nr);
        return mk(1'b1, 1'b1, nl, nr, gl_m, gr_m, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] show_v(input logic [2:0] nl, input logic [2:0] nr);
        return mk(1'b0, 1'b1, nl, nr, gl_m, gr_m, 1'b0, 1'b0);
    endfunction

    // Caller has already observed the first READY cycle.
    task automatic ready_phase(input string tag, input logic poke_start);
        for (int i = 0; i < int'(ReadyCycles) - 1; i++) begin
            start_key = poke_start && (i == 0);
            step({tag, "_ready"}, ready_v());
        end
        start_key = 1'b0;
        step({tag, "_play"}, play_v(3'b000, 3'b000));
    endtask

    // Caller has already observed the first SHOW cycle.
    task automatic finish_show(input string tag, input logic [2:0] lb, input logic [2:0] rb);
        logic lw, rw;
        for (int i = 0; i < int'(ShowCycles) - 1; i++) begin
            step({tag, "_show"}, show_v(lb, rb));
        end
        lw = wins(lb, rb);
        rw = wins(rb, lb);
        if (lw && gl_m < int'(WinScore)) gl_m++;
        if (rw && gr_m < int'(WinScore)) gr_m++;
        if ((lw && gl_m == int'(WinScore)) || (rw && gr_m == int'(WinScore))) begin
            over_vec = mk(1'b0, 1'b0, lb, rb, gl_m, gr_m, 1'b1, lw);
            step({tag, "_over"}, over_vec);
        end else begin
            step({tag, "_score"}, ready_v());
        end
    endtask

    task automatic play_round(input string tag, input logic [2:0] lb, input logic [2:0] rb);
        btn_left  = lb;
        btn_right = rb;
        step({tag, "_latch"}, show_v(lb, rb));
        btn_left  = 3'b000;
        btn_right = 3'b000;
        finish_show(tag, lb, rb);
    endtask

    task automatic start_match(input string tag);
        start_key = 1'b1;
        gl_m = 0;
        gr_m = 0;
        step({tag, "_start"}, ready_v());
        start_key = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start_key = 1'b0;
        btn_left  = 3'b000;
        btn_right = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        step("reset", 16'h0000);
        rst      = 1'b0;
        btn_left = 3'b001;
        step("idle_btn", 16'h0000);
        btn_left = 3'b000;

        start_match("m1");
        ready_phase("m1r1", 1'b0);
        play_round("lw_rock", 3'b001, 3'b010);
        ready_phase("m1r2", 1'b1);
        play_round("tie", 3'b100, 3'b100);
        ready_phase("m1r3", 1'b0);

        // Invalid code then valid; right's later change must be ignored.
        btn_left  = 3'b011;
        btn_right = 3'b001;
        start_key = 1'b1;
        step("inv_a", play_v(3'b000, 3'b001));
        start_key = 1'b0;
        btn_left  = 3'b010;
        btn_right = 3'b100;
        step("inv_b", show_v(3'b010, 3'b001));
        btn_left  = 3'b000;
        btn_right = 3'b000;
        finish_show("inv", 3'b010, 3'b001);

        ready_phase("m1r4", 1'b0);
        play_round("lw_paper", 3'b100, 3'b001);
        ready_phase("m1r5", 1'b0);
        play_round("lw_sciss", 3'b010, 3'b100);

        btn_left  = 3'b001;
        btn_right = 3'b010;
        step("over_hold1", over_vec);
        btn_left  = 3'b100;
        step("over_hold2", over_vec);
        btn_left  = 3'b000;
        btn_right = 3'b000;

        start_match("m2");
        ready_phase("m2r1", 1'b0);
        play_round("rw1", 3'b001, 3'b100);
        ready_phase("m2r2", 1'b0);
        play_round("rw2", 3'b010, 3'b001);
        ready_phase("m2r3", 1'b0);
        play_round("rw3", 3'b100, 3'b010);
        step("over_right", over_vec);

        start_match("m3");
        ready_phase("m3r1", 1'b0);
        play_round("m3a", 3'b001, 3'b010);
        ready_phase("m3r2", 1'b0);
        play_round("m3b", 3'b001, 3'b010);
        ready_phase("m3r3", 1'b0);
        btn_left  = 3'b001;
        btn_right = 3'b010;
        step("rs_latch", show_v(3'b001, 3'b010));
        btn_left  = 3'b000;
        btn_right = 3'b000;
        step("rs_show", show_v(3'b001, 3'b010));
        rst  = 1'b1;
        gl_m = 0;
        gr_m = 0;
        step("rst_mid_show", 16'h0000);
        rst = 1'b0;
        step("post_rst_idle", 16'h0000);

`ifdef RPS_TIMEOUT_EN
        start_match("m4");
        ready_phase("m4r1", 1'b0);
        btn_right = 3'b100;
        step("to_press", play_v(3'b000, 3'b100));
        btn_right = 3'b000;
        for (int i = 0; i < int'(TimeoutCycles) - 2; i++) begin
            step("to_wait", play_v(3'b000, 3'b100));
        end
        step("to_show", show_v(3'b000, 3'b100));
        finish_show("to_one", 3'b000, 3'b100);
        ready_phase("m4r2", 1'b0);
        for (int i = 0; i < int'(TimeoutCycles) - 1; i++) begin
            step("to_none_wait", play_v(3'b000, 3'b000));
        end
        step("to_none_ready", ready_v());
`else
        start_match("m4");
        ready_phase("m4r1", 1'b0);
        for (int i = 0; i < int'(TimeoutCycles) + 2; i++) begin
            step("no_timeout", play_v(3'b000, 3'b000));
        end
        play_round("m4a", 3'b010, 3'b100);
`endif

        @(negedge clk);
        #1;
        check_eq("sb_empty", 16'(sb.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rps_round_ctrl.md
# rps_round_ctrl

Round sequencer for the rock-paper-scissors game. It drives the LED-matrix display block's control inputs (ready_pulse, start_pulse, new_button_left/right, grade_left/right) from the player buttons and the start key. It runs the ready → play → show → score loop, judges each round, keeps both scores and declares the match winner. It sits between the debounced button front end and the matrix display block.

## Interface
- READY_CYCLES, default 50_000_000: cycles the "ready" phase lasts (1 s at 50 MHz)
- SHOW_CYCLES, default 100_000_000: cycles both throws are displayed before scoring
- TIMEOUT_CYCLES, default 250_000_000: play-phase limit (used only with RPS_TIMEOUT_EN)
- WIN_SCORE, default 3: points that end the match (1..7)
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- start_key  in  1  debounced single-cycle pulse: begin match / restart after match end
- btn_left  in  3  debounced level, one-hot throw: 001 rock, 010 scissors, 100 paper, 000 none
- btn_right  in  3  same encoding, right player
- ready_pulse  out  1  high throughout READY and PLAY
- start_pulse  out  1  high throughout PLAY and SHOW
- new_button_left  out  3  latched left throw; 000 when not latched
- new_button_right  out  3  latched right throw
- grade_left  out  3  left score, 0..WIN_SCORE
- grade_right  out  3  right score
- match_over  out  1  high in OVER
- winner_left  out  1  in OVER: 1 = left won, 0 = right won

## Operation
- States: IDLE, READY, PLAY, SHOW, OVER.
- IDLE: all outputs 0. start_key → READY. Grades clear and the phase counter loads 0.
- READY: ready_pulse=1. Counter runs to READY_CYCLES-1 → PLAY. Throws clear to 000.
- PLAY: ready_pulse=1, start_pulse=1.
  - Each side latches the first one-hot value seen on its button.
  - Non-one-hot codes (000, 011, 111, …) are ignored.
  - Once a side has latched, later changes on that side are ignored.
  - When both sides are latched → SHOW.
- SHOW: start_pulse=1, throws held. Counter runs to SHOW_CYCLES-1. Then the round is judged and the next state chosen:
  - Rock beats scissors, scissors beats paper, paper beats rock.
  - The round winner's grade increments by 1. A tie changes no score.
  - If the incremented grade equals WIN_SCORE → OVER. Otherwise → READY.
- OVER: match_over=1. winner_left is set. Grades and final throws are held. start_key → READY with grades cleared.
- start_key in READY, PLAY or SHOW is ignored.
- Grades saturate at WIN_SCORE. They never wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE, every output 0, counters 0.
- A state change takes effect the cycle after its condition.
  - start_key sampled high in IDLE → ready_pulse=1 on the next cycle.
  - READY lasts exactly READY_CYCLES cycles. SHOW lasts exactly SHOW_CYCLES cycles.
- Throw latch: a one-hot button value sampled at edge N appears on new_button_* at edge N+1.
  - If both sides latch in the same cycle, SHOW is entered the cycle after.
- Grade update and the READY/OVER entry occur on the same edge, which is the last SHOW cycle + 1.
- rst high at any time (mid-round included) forces the reset values on the next edge. All latched throws and scores are lost.

## Configuration
- RPS_TIMEOUT_EN defined:
  - PLAY has a counter limited to TIMEOUT_CYCLES.
  - On expiry with one side latched: the latched side wins the round. The missing throw shows 000 during SHOW, then scoring proceeds normally.
  - On expiry with neither side latched: → READY, no score change.
- RPS_TIMEOUT_EN undefined: PLAY waits indefinitely and TIMEOUT_CYCLES is unused.

## Test plan
Bench parameters: READY_CYCLES=4, SHOW_CYCLES=3, TIMEOUT_CYCLES=10, WIN_SCORE=3.
- Reset, then start_key pulse → ready_pulse rises 1 cycle later, stays high for 4 cycles, then start_pulse=1 and ready_pulse=1 (PLAY).
- In PLAY, left=001, right=010 in the same cycle → new_button_left=001, new_button_right=010 next cycle. After 3 SHOW cycles, grade_left=1, grade_right=0, and ready_pulse=1 again.
- Left=100 and right=100 → tie. Grades unchanged and a new READY begins.
- Left=011 (invalid), then 010; right=001 → left latches 010 only. Right wins: grade_right increments.
- Left wins 3 rounds → grade_left=3, match_over=1, winner_left=1. Buttons are then ignored. start_key → grades 0, READY.
- rst asserted mid-SHOW with grade_left=2 → next cycle: all outputs 0, state IDLE.
- With RPS_TIMEOUT_EN: only right presses 100, 10 cycles elapse → new_button_left=000 in SHOW, then grade_right+1. With neither side pressing → back to READY, grades unchanged.
